// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam int DEF_BAUD_DIV = 2604;

  function automatic logic parity9(input logic [8:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/uart_fifo_sync.sv
// Single-clock FIFO; dout shows the head word combinationally, pushes while full are ignored.
module uart_fifo_sync #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_push;
  logic              w_pop;

  assign full   = (r_cnt == CNT_W'(FIFO_DEPTH));
  assign empty  = (r_cnt == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign dout   = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// UART transmitter fed by a small FIFO; frames leave back-to-back, TX falls two clocks after a push into an idle block.
// Define UART_TX_PARITY_EN to add a parity bit and the par_odd input.
module uart_tx_fifo_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int BAUD_DIV   = DEF_BAUD_DIV,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef UART_TX_PARITY_EN
  input  logic              par_odd,
`endif
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              overflow,
  output logic              TX,
  output logic              busy,
  output logic              tx_done
);

  localparam int BAUD_W = $clog2(BAUD_DIV);
  localparam int BIT_W  = $clog2(DATA_W + 1);

  tx_state_t         r_state;
  tx_state_t         w_state_nxt;
  logic [BAUD_W-1:0] r_baud_cnt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_shreg;
  logic              r_tx;
  logic              r_tx_done;
  logic              r_overflow;
  logic [DATA_W-1:0] w_fifo_dout;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_tx;
  logic              w_done;
  logic              w_shift;
  logic              w_bit_end;
  logic              w_last_bit;
  logic              w_last_stop;
`ifdef UART_TX_PARITY_EN
  logic              r_par;
`endif

  uart_fifo_sync #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (wr_en),
    .pop  (w_pop),
    .din  (wr_data),
    .dout (w_fifo_dout),
    .empty(w_empty),
    .full (w_full)
  );

  assign w_bit_end   = (r_baud_cnt == BAUD_W'(BAUD_DIV - 1));
  assign w_last_bit  = (r_bit_cnt == BIT_W'(DATA_W - 1));
  assign w_last_stop = (r_bit_cnt == BIT_W'(STOP_BITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_tx        = 1'b1;
    w_done      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        w_tx = 1'b0;
        if (w_bit_end) w_state_nxt = DATA;
      end
      DATA: begin
        w_tx = r_shreg[0];
        if (w_bit_end) begin
          w_shift = 1'b1;
`ifdef UART_TX_PARITY_EN
          if (w_last_bit) w_state_nxt = PARITY;
`else
          if (w_last_bit) w_state_nxt = STOP;
`endif
        end
      end
      PARITY: begin
`ifdef UART_TX_PARITY_EN
        w_tx = r_par;
`endif
        if (w_bit_end) w_state_nxt = STOP;
      end
      STOP: begin
        // Chaining straight into START keeps queued frames gap-free.
        if (w_bit_end && w_last_stop) begin
          w_done = 1'b1;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shreg    <= '0;
      r_tx       <= 1'b1;
      r_tx_done  <= 1'b0;
      r_overflow <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_tx      <= w_tx;
      r_tx_done <= w_done;
      if (wr_en && w_full) r_overflow <= 1'b1;

      if (r_state == IDLE || w_bit_end) r_baud_cnt <= '0;
      else                              r_baud_cnt <= r_baud_cnt + BAUD_W'(1);

      // Bit counter is reused for data bits and stop bits; it restarts on every state change.
      if (w_state_nxt != r_state) r_bit_cnt <= '0;
      else if (w_bit_end)         r_bit_cnt <= r_bit_cnt + BIT_W'(1);

      if (w_pop) begin
        r_shreg <= w_fifo_dout;
`ifdef UART_TX_PARITY_EN
        r_par   <= parity9(9'(w_fifo_dout)) ^ par_odd;
`endif
      end else if (w_shift) begin
        r_shreg <= r_shreg >> 1;
      end
    end
  end

  assign TX       = r_tx;
  assign busy     = (r_state != IDLE);
  assign tx_done  = r_tx_done;
  assign overflow = r_overflow;
  assign full     = w_full;

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Bench for uart_tx_fifo_cfg: an 8N1 instance and a 7-bit two-stop instance, checked against frames built from words.
module tb_uart_tx_fifo_cfg;

  localparam int BD = 16;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       wr_en1, wr_en2;
  logic [7:0] wr_data1;
  logic [6:0] wr_data2;
  logic       full1, ovf1, tx1, busy1, done1;
  logic       full2, ovf2, tx2, busy2, done2;
`ifdef UART_TX_PARITY_EN
  logic       par_odd;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [8:0] exp_words[$];

  uart_tx_fifo_cfg #(.DATA_W(8), .BAUD_DIV(BD), .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst_n(rst_n),
`ifdef UART_TX_PARITY_EN
    .par_odd(par_odd),
`endif
    .wr_en(wr_en1), .wr_data(wr_data1), .full(full1), .overflow(ovf1),
    .TX(tx1), .busy(busy1), .tx_done(done1)
  );

  uart_tx_fifo_cfg #(.DATA_W(7), .BAUD_DIV(BD), .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst_n(rst_n),
`ifdef UART_TX_PARITY_EN
    .par_odd(par_odd),
`endif
    .wr_en(wr_en2), .wr_data(wr_data2), .full(full2), .overflow(ovf2),
    .TX(tx2), .busy(busy2), .tx_done(done2)
  );

  function automatic logic tx_of(input int sel);
    return (sel == 1) ? tx2 : tx1;
  endfunction
  function automatic logic busy_of(input int sel);
    return (sel == 1) ? busy2 : busy1;
  endfunction
  function automatic logic done_of(input int sel);
    return (sel == 1) ? done2 : done1;
  endfunction

  task automatic push_words(input int sel);
    foreach (exp_words[i]) begin
      @(negedge clk);
      if (sel == 1) begin wr_en2 = 1'b1; wr_data2 = exp_words[i][6:0]; end
      else          begin wr_en1 = 1'b1; wr_data1 = exp_words[i][7:0]; end
    end
    @(negedge clk);
    wr_en1 = 1'b0;
    wr_en2 = 1'b0;
  endtask

  // Expects exp_words as contiguous frames; started=1 means the current sample is the first start-bit clock.
  task automatic run_stream(input int sel, input int dw, input int sb, input bit odd,
                            input bit started, input string nm);
    int fl, bad_tx, bad_busy, bad_done;
    bit found, p;
    logic [12:0] bits;
    logic [8:0] w;
    logic e_tx, e_busy, e_done, a_tx, a_busy, a_done;
    fl = (1 + dw + (PAR_EN ? 1 : 0) + sb) * BD;
    found = started;
    if (!started) begin
      for (int c = 0; c < 400 && !found; c++) begin
        @(posedge clk); #1;
        if (tx_of(sel) === 1'b0) found = 1'b1;
      end
      n_checks++;
      if (!found) begin
        $display("FAIL %s_start: TX stayed %b for 400 clocks, required a falling start bit", nm, tx_of(sel));
        return;
      end
      n_pass++;
    end
    foreach (exp_words[f]) begin
      w = exp_words[f];
      bits = '1;
      bits[0] = 1'b0;
      p = odd;
      for (int i = 0; i < dw; i++) begin
        bits[1+i] = w[i];
        p ^= w[i];
      end
      if (PAR_EN) bits[1+dw] = p;
      bad_tx = -1; bad_busy = -1; bad_done = -1;
      a_tx = 1'b0; a_busy = 1'b0; a_done = 1'b0;
      e_tx = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      for (int k = 0; k < fl; k++) begin
        if (f > 0 || k > 0) begin @(posedge clk); #1; end
        if (bad_tx < 0 && tx_of(sel) !== bits[k/BD]) begin
          bad_tx = k; a_tx = tx_of(sel); e_tx = bits[k/BD];
        end
        if (bad_done < 0 && done_of(sel) !== (k == fl - 1)) begin
          bad_done = k; a_done = done_of(sel); e_done = (k == fl - 1);
        end
        if (bad_busy < 0 && busy_of(sel) !== !(k == fl - 1 && f == exp_words.size() - 1)) begin
          bad_busy = k; a_busy = busy_of(sel); e_busy = !(k == fl - 1 && f == exp_words.size() - 1);
        end
      end
      n_checks++;
      if (bad_tx >= 0) $display("FAIL %s_tx frame %0d word %h: clk %0d TX=%b required %b", nm, f, w, bad_tx, a_tx, e_tx);
      else n_pass++;
      n_checks++;
      if (bad_done >= 0) $display("FAIL %s_done frame %0d: clk %0d tx_done=%b required %b", nm, f, bad_done, a_done, e_done);
      else n_pass++;
      n_checks++;
      if (bad_busy >= 0) $display("FAIL %s_busy frame %0d: clk %0d busy=%b required %b", nm, f, bad_busy, a_busy, e_busy);
      else n_pass++;
    end
    @(posedge clk); #1;
    n_checks++;
    if (tx_of(sel) !== 1'b1 || busy_of(sel) !== 1'b0)
      $display("FAIL %s_idle: TX=%b busy=%b required TX=1 busy=0", nm, tx_of(sel), busy_of(sel));
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (tx1 !== 1'b1) $display("FAIL reset_tx: TX=%b required 1", tx1); else n_pass++;
    n_checks++; if (busy1 !== 1'b0) $display("FAIL reset_busy: busy=%b required 0", busy1); else n_pass++;
    n_checks++; if (done1 !== 1'b0) $display("FAIL reset_done: tx_done=%b required 0", done1); else n_pass++;
    n_checks++; if (full1 !== 1'b0) $display("FAIL reset_full: full=%b required 0", full1); else n_pass++;
    n_checks++; if (ovf1 !== 1'b0) $display("FAIL reset_ovf: overflow=%b required 0", ovf1); else n_pass++;
    n_checks++;
    if ({tx2, busy2, done2, full2, ovf2} !== 5'b10000)
      $display("FAIL reset_dut2: {TX,busy,done,full,ovf}=%b required 10000", {tx2, busy2, done2, full2, ovf2});
    else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_a5();
    exp_words = {9'h0A5};
    @(negedge clk); wr_en1 = 1'b1; wr_data1 = 8'hA5;
    @(posedge clk); #1;
    @(negedge clk); wr_en1 = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (tx1 !== 1'b1 || busy1 !== 1'b1) $display("FAIL lat_n1: TX=%b busy=%b required TX=1 busy=1", tx1, busy1);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (tx1 !== 1'b0) $display("FAIL lat_n2: TX=%b required 0", tx1); else n_pass++;
    run_stream(0, 8, 1, 1'b0, 1'b1, "single_a5");
  endtask

  task automatic test_back_to_back();
    exp_words = {9'h055, 9'h0AA, 9'h00F};
    fork
      push_words(0);
      run_stream(0, 8, 1, 1'b0, 1'b0, "b2b");
    join
  endtask

  task automatic test_overflow();
    logic [7:0] words[6];
    n_checks++;
    if (ovf1 !== 1'b0) $display("FAIL ovf_pre: overflow=%b required 0", ovf1); else n_pass++;
    for (int i = 0; i < 6; i++) words[i] = 8'($urandom);
    exp_words = {};
    for (int i = 0; i < 5; i++) exp_words.push_back({1'b0, words[i]});
    fork
      begin
        @(negedge clk); wr_en1 = 1'b1; wr_data1 = words[0];
        @(negedge clk); wr_en1 = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 1; i < 6; i++) begin
          wr_en1 = 1'b1; wr_data1 = words[i];
          @(posedge clk); #1;
          n_checks++;
          if (full1 !== (i >= 4)) $display("FAIL ovf_full%0d: full=%b required %b", i, full1, (i >= 4));
          else n_pass++;
          n_checks++;
          if (ovf1 !== (i >= 5)) $display("FAIL ovf_flag%0d: overflow=%b required %b", i, ovf1, (i >= 5));
          else n_pass++;
          @(negedge clk);
        end
        wr_en1 = 1'b0;
      end
      run_stream(0, 8, 1, 1'b0, 1'b0, "overflow");
    join
    n_checks++;
    if (ovf1 !== 1'b1 || full1 !== 1'b0) $display("FAIL ovf_sticky: overflow=%b full=%b required 1 0", ovf1, full1);
    else n_pass++;
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 3; it++) begin
      n = $urandom_range(1, 5);
      exp_words = {};
      for (int i = 0; i < n; i++) exp_words.push_back({1'b0, 8'($urandom)});
      fork
        push_words(0);
        run_stream(0, 8, 1, 1'b0, 1'b0, "random");
      join
    end
  endtask

  task automatic test_reset_mid();
    bit found, quiet;
    exp_words = {9'h03C, 9'h0C3, 9'h099};
    push_words(0);
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(posedge clk); #1;
      if (tx1 === 1'b0) found = 1'b1;
    end
    n_checks++;
    if (!found) $display("FAIL rstmid_start: TX=%b never fell, required 0", tx1); else n_pass++;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (tx1 !== 1'b1) $display("FAIL rstmid_tx: TX=%b required 1", tx1); else n_pass++;
    n_checks++; if (busy1 !== 1'b0) $display("FAIL rstmid_busy: busy=%b required 0", busy1); else n_pass++;
    n_checks++;
    if (full1 !== 1'b0 || ovf1 !== 1'b0) $display("FAIL rstmid_flags: full=%b overflow=%b required 0 0", full1, ovf1);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    quiet = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (tx1 !== 1'b1 || busy1 !== 1'b0) quiet = 1'b0;
    end
    n_checks++;
    if (!quiet) $display("FAIL rstmid_flush: queued data sent after reset, quiet=%b required 1", quiet); else n_pass++;
    exp_words = {{1'b0, 8'($urandom)}};
    fork
      push_words(0);
      run_stream(0, 8, 1, 1'b0, 1'b0, "post_reset");
    join
  endtask

  task automatic test_stop2();
    exp_words = {9'h07F, {2'b00, 7'($urandom)}};
    fork
      push_words(1);
      run_stream(1, 7, 2, 1'b0, 1'b0, "stop2");
    join
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    par_odd = 1'b0;
    exp_words = {9'h007};
    fork
      push_words(0);
      run_stream(0, 8, 1, 1'b0, 1'b0, "par_even");
    join
    par_odd = 1'b1;
    fork
      push_words(0);
      run_stream(0, 8, 1, 1'b1, 1'b0, "par_odd");
    join
    par_odd = 1'b0;
  endtask
`endif

  initial begin
    wr_en1 = 1'b0; wr_en2 = 1'b0; wr_data1 = '0; wr_data2 = '0;
`ifdef UART_TX_PARITY_EN
    par_odd = 1'b0;
`endif
    test_reset();
    test_single_a5();
    test_back_to_back();
    test_overflow();
    test_random();
    test_reset_mid();
    test_stop2();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
